uart_tx_arbiter: RTL and testbench

- Round-robin scheduler sharing the TX half of one UART_TX_RX_MODULE among NUM_REQUESTERS clients.
- Captures the granted client's byte, drives the module's launch/data inputs, tracks TX_ACTIVE/TX_DONE and reports per-client ack, done or timeout-error.
- Sits between client logic (protocol engines, loopback responders) and the UART TX ports.
- The RX side is not touched.

---
 rtl/uart_tx_arbiter.sv | 257 +++++++++++++++++++++++++
 tb/tb_uart_tx_arbiter.sv | 333 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter: round-robin scheduler that shares one UART transmitter
//   between NUM_REQUESTERS clients and reports ack / done / error per client.
// Latency: ACK one cycle after a request is sampled in IDLE; launch is held
//   until the UART reports active, or until the launch timeout expires.
// Backpressure: a client holds IN_REQ until its ACK. No new grant is made
//   while a frame is in flight or while the UART still reports active.
//
// Ports:
//   IN_CLOCK, IN_RESET       clock, synchronous active-high reset
//   IN_REQ / IN_REQ_DATA     per-client request level and flattened data
//                            (client i at bits [i*W +: W])
//   OUT_REQ_ACK/DONE/ERROR   one-hot, single-cycle status pulses per client
//   OUT_BUSY                 high whenever the scheduler is not idle
//   OUT_GRANT_INDEX          current or last granted client
//   OUT_UART_TX_LAUNCH/DATA  to the UART transmitter
//   IN_UART_TX_ACTIVE/DONE   from the UART transmitter
module uart_tx_arbiter #(
  parameter int NUM_REQUESTERS           = 4,
  parameter int NUM_OF_DATA_BITS_IN_PACK = 8,
  parameter int LAUNCH_TIMEOUT_CYCLES    = 16,
  parameter int FRAME_TIMEOUT_CYCLES     = 4096
) (
  input  logic                                                IN_CLOCK,
  input  logic                                                IN_RESET,
  input  logic [NUM_REQUESTERS-1:0]                           IN_REQ,
  input  logic [NUM_REQUESTERS*NUM_OF_DATA_BITS_IN_PACK-1:0]  IN_REQ_DATA,
  output logic [NUM_REQUESTERS-1:0]                           OUT_REQ_ACK,
  output logic [NUM_REQUESTERS-1:0]                           OUT_REQ_DONE,
  output logic [NUM_REQUESTERS-1:0]                           OUT_REQ_ERROR,
  output logic                                                OUT_BUSY,
  output logic [$clog2(NUM_REQUESTERS)-1:0]                   OUT_GRANT_INDEX,
  output logic                                                OUT_UART_TX_LAUNCH,
  output logic [NUM_OF_DATA_BITS_IN_PACK-1:0]                 OUT_UART_TX_DATA,
  input  logic                                                IN_UART_TX_ACTIVE,
  input  logic                                                IN_UART_TX_DONE
);

  localparam int W           = NUM_OF_DATA_BITS_IN_PACK;
  localparam int IDX_W       = $clog2(NUM_REQUESTERS);
  localparam int MAX_TIMEOUT = (LAUNCH_TIMEOUT_CYCLES > FRAME_TIMEOUT_CYCLES) ?
                               LAUNCH_TIMEOUT_CYCLES : FRAME_TIMEOUT_CYCLES;
  localparam int CNT_W       = $clog2(MAX_TIMEOUT + 1);

  localparam logic [CNT_W-1:0] LAUNCH_LAST = CNT_W'(LAUNCH_TIMEOUT_CYCLES - 1);
  localparam logic [CNT_W-1:0] FRAME_LAST  = CNT_W'(FRAME_TIMEOUT_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE     = CNT_W'(1);
  localparam logic [IDX_W:0]   N_EXT       = (IDX_W + 1)'(NUM_REQUESTERS);
  localparam logic [IDX_W-1:0] LAST_IDX    = IDX_W'(NUM_REQUESTERS - 1);
  localparam logic [IDX_W-1:0] IDX_ONE     = IDX_W'(1);

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_LAUNCH   = 2'd1,
    ST_BUSY     = 2'd2,
    ST_COMPLETE = 2'd3
  } state_t;

  // ------------------------------------------------------------------
  // State and registered outputs
  // ------------------------------------------------------------------
  state_t           state_q, state_nxt;
  logic [IDX_W-1:0] grant_q, grant_nxt;
  logic [IDX_W-1:0] ptr_q, ptr_nxt;
  logic [W-1:0]     data_q, data_nxt;
  logic             launch_q, launch_nxt;
  logic [CNT_W-1:0] cnt_q, cnt_nxt;
  logic [NUM_REQUESTERS-1:0] ack_q, ack_nxt;
  logic [NUM_REQUESTERS-1:0] done_q, done_nxt;
  logic [NUM_REQUESTERS-1:0] err_q, err_nxt;

  // ------------------------------------------------------------------
  // Round-robin winner: first set request scanning upward from ptr_q.
  // The candidate index is formed one bit wider and folded back once,
  // which is enough because ptr_q < N and the offset < N.
  // ------------------------------------------------------------------
  logic             win_found;
  logic [IDX_W-1:0] win_idx;
  logic [IDX_W:0]   cand;
  logic [W-1:0]     win_data;

  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
    cand      = '0;
    for (int i = 0; i < NUM_REQUESTERS; i++) begin
      cand = {1'b0, ptr_q} + (IDX_W + 1)'(i);
      if (cand >= N_EXT) begin
        cand = cand - N_EXT;
      end
      if (!win_found && IN_REQ[cand[IDX_W-1:0]]) begin
        win_found = 1'b1;
        win_idx   = cand[IDX_W-1:0];
      end
    end
  end

  assign win_data = IN_REQ_DATA[int'(win_idx) * W +: W];

  // ------------------------------------------------------------------
  // Decision terms shared by the next-state and output logic
  // ------------------------------------------------------------------
  logic             arb_go;
  logic             launch_expire;
  logic             frame_expire;
  logic [IDX_W-1:0] ptr_after;

  // A grant needs the UART to be idle as well: after an aborted or timed
  // out frame the transmitter may still be shifting out the old byte.
  assign arb_go        = win_found && !IN_UART_TX_ACTIVE;
  assign launch_expire = !IN_UART_TX_ACTIVE && (cnt_q == LAUNCH_LAST);
  // DONE takes priority over a frame timeout landing on the same cycle.
  assign frame_expire  = !IN_UART_TX_DONE && (cnt_q == FRAME_LAST);
  assign ptr_after     = (grant_q == LAST_IDX) ? '0 : grant_q + IDX_ONE;

  // ------------------------------------------------------------------
  // FSM: state register
  // ------------------------------------------------------------------
  always_ff @(posedge IN_CLOCK) begin
    if (IN_RESET) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_nxt;
    end
  end

  // ------------------------------------------------------------------
  // FSM: next-state logic
  // ------------------------------------------------------------------
  always_comb begin
    state_nxt = state_q;
    case (state_q)
      ST_IDLE: begin
        if (arb_go) begin
          state_nxt = ST_LAUNCH;
        end
      end
      ST_LAUNCH: begin
        if (IN_UART_TX_ACTIVE) begin
          state_nxt = ST_BUSY;
        end else if (launch_expire) begin
          state_nxt = ST_IDLE;
        end
      end
      ST_BUSY: begin
        if (IN_UART_TX_DONE) begin
          state_nxt = ST_COMPLETE;
        end else if (frame_expire) begin
          state_nxt = ST_IDLE;
        end
      end
      ST_COMPLETE: begin
        state_nxt = ST_IDLE;
      end
      default: begin
        state_nxt = ST_IDLE;
      end
    endcase
  end

  // ------------------------------------------------------------------
  // FSM: output / datapath logic (values loaded at the next edge)
  // ------------------------------------------------------------------
  always_comb begin
    grant_nxt  = grant_q;
    ptr_nxt    = ptr_q;
    data_nxt   = data_q;
    launch_nxt = launch_q;
    cnt_nxt    = cnt_q;
    ack_nxt    = '0;
    done_nxt   = '0;
    err_nxt    = '0;
    case (state_q)
      ST_IDLE: begin
        if (arb_go) begin
          grant_nxt        = win_idx;
          data_nxt         = win_data;
          ack_nxt[win_idx] = 1'b1;
          launch_nxt       = 1'b1;
          cnt_nxt          = '0;
        end
      end
      ST_LAUNCH: begin
        if (IN_UART_TX_ACTIVE) begin
          launch_nxt = 1'b0;
          cnt_nxt    = '0;
        end else if (launch_expire) begin
          launch_nxt       = 1'b0;
          err_nxt[grant_q] = 1'b1;
          ptr_nxt          = ptr_after;
          data_nxt         = '0;
          cnt_nxt          = '0;
        end else begin
          cnt_nxt = cnt_q + CNT_ONE;
        end
      end
      ST_BUSY: begin
        launch_nxt = 1'b0;
        if (IN_UART_TX_DONE) begin
          done_nxt[grant_q] = 1'b1;
          ptr_nxt           = ptr_after;
          cnt_nxt           = '0;
        end else if (frame_expire) begin
          err_nxt[grant_q] = 1'b1;
          ptr_nxt          = ptr_after;
          data_nxt         = '0;
          cnt_nxt          = '0;
        end else begin
          cnt_nxt = cnt_q + CNT_ONE;
        end
      end
      ST_COMPLETE: begin
        // Byte stays on the bus through the done cycle, then is cleared.
        data_nxt = '0;
        cnt_nxt  = '0;
      end
      default: begin
        launch_nxt = 1'b0;
        cnt_nxt    = '0;
      end
    endcase
  end

  // ------------------------------------------------------------------
  // Datapath / output registers. Reset drops everything, including an
  // in-flight grant, without reporting DONE or ERROR for it.
  // ------------------------------------------------------------------
  always_ff @(posedge IN_CLOCK) begin
    if (IN_RESET) begin
      grant_q  <= '0;
      ptr_q    <= '0;
      data_q   <= '0;
      launch_q <= 1'b0;
      cnt_q    <= '0;
      ack_q    <= '0;
      done_q   <= '0;
      err_q    <= '0;
    end else begin
      grant_q  <= grant_nxt;
      ptr_q    <= ptr_nxt;
      data_q   <= data_nxt;
      launch_q <= launch_nxt;
      cnt_q    <= cnt_nxt;
      ack_q    <= ack_nxt;
      done_q   <= done_nxt;
      err_q    <= err_nxt;
    end
  end

  assign OUT_REQ_ACK        = ack_q;
  assign OUT_REQ_DONE       = done_q;
  assign OUT_REQ_ERROR      = err_q;
  assign OUT_BUSY           = (state_q != ST_IDLE);
  assign OUT_GRANT_INDEX    = grant_q;
  assign OUT_UART_TX_LAUNCH = launch_q;
  assign OUT_UART_TX_DATA   = data_q;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// tb_uart_tx_arbiter: randomized scoreboard bench for uart_tx_arbiter with a
//   behavioural UART transmitter model (normal, no-active, never-done frames).
module tb_uart_tx_arbiter;

  localparam int N = 4;
  localparam int W = 8;

  logic           clk;
  logic           rst;
  logic [N-1:0]   req;
  logic [W-1:0]   dat [N];
  logic [N*W-1:0] req_data;
  logic [N-1:0]   ack, done, err;
  logic           busy;
  logic [1:0]     gidx;
  logic           launch;
  logic [W-1:0]   txdata;
  logic           uart_active;
  logic           uart_done;

  assign req_data = {dat[3], dat[2], dat[1], dat[0]};

  uart_tx_arbiter #(
    .NUM_REQUESTERS(N),
    .NUM_OF_DATA_BITS_IN_PACK(W),
    .LAUNCH_TIMEOUT_CYCLES(16),
    .FRAME_TIMEOUT_CYCLES(4096)
  ) dut (
    .IN_CLOCK(clk),
    .IN_RESET(rst),
    .IN_REQ(req),
    .IN_REQ_DATA(req_data),
    .OUT_REQ_ACK(ack),
    .OUT_REQ_DONE(done),
    .OUT_REQ_ERROR(err),
    .OUT_BUSY(busy),
    .OUT_GRANT_INDEX(gidx),
    .OUT_UART_TX_LAUNCH(launch),
    .OUT_UART_TX_DATA(txdata),
    .IN_UART_TX_ACTIVE(uart_active),
    .IN_UART_TX_DONE(uart_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // kind: 0 = ACK, 1 = DONE, 2 = ERROR
  // len : ACK -> expected launch-high cycles; ERROR -> expected cycles in BUSY
  typedef struct {
    int         kind;
    int         idx;
    logic [7:0] dat;
    int         len;
  } exp_t;

  // mode: 0 = normal frame, 1 = ACTIVE never rises, 2 = DONE never arrives
  typedef struct {
    int mode;
    int dly;
    int len;
  } uart_t;

  exp_t  exp_q   [$];
  uart_t mode_q  [$];
  uart_t force_q [$];

  int n_cmp   = 0;
  int n_bad   = 0;
  int m_ptr   = 0;
  int ft_rand = 0;
  bit aborted = 1'b0;

  task automatic chk(input bit ok, input string name, input longint act, input longint req_v);
    n_cmp++;
    if (!ok) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, req_v, $time);
    end
  endtask

  // ------------------------------------------------------------------
  // UART transmitter model
  // ------------------------------------------------------------------
  initial begin
    uart_t u;
    uart_active = 1'b0;
    uart_done   = 1'b0;
    forever begin
      @(negedge clk);
      if (!rst && launch && mode_q.size() > 0) begin
        u = mode_q.pop_front();
        if (u.mode == 1) begin
          for (int k = 0; k < 40 && launch; k++) @(negedge clk);
        end else begin
          repeat (u.dly) @(negedge clk);
          uart_active = 1'b1;
          if (u.mode == 0) begin
            repeat (u.len) @(negedge clk);
            uart_done = 1'b1;
            @(negedge clk);
            uart_done   = 1'b0;
            uart_active = 1'b0;
          end else begin
            for (int k = 0; k < 5000 && !(|err); k++) @(negedge clk);
            uart_active = 1'b0;
          end
        end
      end
    end
  end

  // ------------------------------------------------------------------
  // Monitor: pops the scoreboard on every status pulse
  // ------------------------------------------------------------------
  int l_cnt    = 0;
  int b_cnt    = 0;
  int exp_llen = 0;

  task automatic take(input int kind, input logic [N-1:0] vec);
    exp_t         e;
    logic [N-1:0] onehot;
    if (exp_q.size() == 0) begin
      n_cmp++;
      n_bad++;
      $display("FAIL unexpected_pulse: kind %0d vector %b, expected none (t=%0t)", kind, vec, $time);
      return;
    end
    e = exp_q.pop_front();
    onehot = '0;
    onehot[e.idx] = 1'b1;
    chk(e.kind == kind, "event_kind", kind, e.kind);
    chk(vec == onehot, "event_client", vec, onehot);
    if (kind == 0) begin
      chk(gidx == 2'(e.idx), "grant_index", gidx, e.idx);
      chk(txdata == e.dat, "tx_data", txdata, e.dat);
      exp_llen = e.len;
      b_cnt    = 0;
    end
    if (kind == 2) begin
      chk(b_cnt == e.len, "busy_len_at_error", b_cnt, e.len);
    end
  endtask

  always @(negedge clk) begin
    int np;
    if (rst) begin
      l_cnt = 0;
      b_cnt = 0;
    end else begin
      np = int'(|ack) + int'(|done) + int'(|err);
      if (np > 0) chk(np == 1, "pulse_exclusive", np, 1);
      if (|ack)  take(0, ack);
      if (|done) take(1, done);
      if (|err)  take(2, err);
      if (launch) begin
        l_cnt++;
      end else if (l_cnt > 0) begin
        chk(l_cnt == exp_llen, "launch_len", l_cnt, exp_llen);
        l_cnt = 0;
      end
      if (busy && !launch) b_cnt++;
    end
  end

  // ------------------------------------------------------------------
  // Stimulus + reference model
  // ------------------------------------------------------------------
  function automatic uart_t rand_uart();
    uart_t u;
    int    r;
    r     = $urandom_range(0, 15);
    u.dly = $urandom_range(0, 5);
    u.len = $urandom_range(1, 60);
    if (r < 2) begin
      u.mode = 1;
    end else if (r == 2 && ft_rand < 1) begin
      u.mode  = 2;
      ft_rand = ft_rand + 1;
    end else begin
      u.mode = 0;
    end
    return u;
  endfunction

  // Clients in 'mask' request together. hold_k == 0: each client releases
  // after its ACK. hold_k > 0: all stay high for hold_k grants.
  task automatic run_phase(input logic [N-1:0] mask, input int hold_k);
    logic [N-1:0] rem;
    int           n, w, acks, cyc;
    uart_t        u;
    exp_t         e;
    if (aborted) return;
    rem = mask;
    n   = (hold_k > 0) ? hold_k : $countones(mask);
    for (int g = 0; g < n; g++) begin
      w = -1;
      for (int s = 0; s < N; s++) begin
        if (w < 0 && rem[(m_ptr + s) % N]) w = (m_ptr + s) % N;
      end
      m_ptr = (w + 1) % N;
      if (hold_k == 0) rem[w] = 1'b0;
      if (force_q.size() > 0) u = force_q.pop_front();
      else u = rand_uart();
      mode_q.push_back(u);
      e = '{0, w, dat[w], (u.mode == 1) ? 16 : u.dly + 1};
      exp_q.push_back(e);
      e = '{(u.mode == 0) ? 1 : 2, w, 8'h00, (u.mode == 2) ? 4096 : 0};
      exp_q.push_back(e);
    end
    req  = mask;
    acks = 0;
    cyc  = 0;
    while (!(acks == n && exp_q.size() == 0 && !busy && !uart_active) && cyc < 12000) begin
      @(negedge clk);
      #1;
      cyc++;
      if (|ack) begin
        acks++;
        if (acks == 1) chk(cyc == 1, "ack_latency", cyc, 1);
        if (hold_k == 0) req = req & ~ack;
        else if (acks == hold_k) req = '0;
      end
    end
    if (cyc >= 12000) begin
      n_cmp++;
      n_bad++;
      $display("FAIL phase_timeout: %0d acks of %0d, %0d events pending", acks, n, exp_q.size());
      exp_q.delete();
      mode_q.delete();
      req     = '0;
      aborted = 1'b1;
    end
  endtask

  task automatic check_all_zero(input string tag);
    chk(ack == '0,     {tag, "_ack"},    ack,    0);
    chk(done == '0,    {tag, "_done"},   done,   0);
    chk(err == '0,     {tag, "_error"},  err,    0);
    chk(busy == 1'b0,  {tag, "_busy"},   busy,   0);
    chk(gidx == '0,    {tag, "_grant"},  gidx,   0);
    chk(launch == 1'b0,{tag, "_launch"}, launch, 0);
    chk(txdata == '0,  {tag, "_data"},   txdata, 0);
  endtask

  initial begin
    bit    got;
    uart_t u;
    exp_t  e;
    rst = 1'b1;
    req = '0;
    for (int i = 0; i < N; i++) dat[i] = '0;
    repeat (3) @(negedge clk);
    #1;
    check_all_zero("reset");
    rst   = 1'b0;
    m_ptr = 0;

    // Fairness: all four held for five grants -> 0,1,2,3,0
    dat[0] = 8'h10; dat[1] = 8'h20; dat[2] = 8'h30; dat[3] = 8'h40;
    run_phase(4'b1111, 5);

    // Single client, ACTIVE two cycles after launch, DONE 40 cycles later
    dat[0] = 8'h55;
    force_q.push_back('{0, 1, 40});
    run_phase(4'b0001, 0);

    // Launch timeout on the first grant, next requester served normally
    dat[0] = 8'hA1; dat[1] = 8'hB2;
    force_q.push_back('{1, 0, 0});
    force_q.push_back('{0, 3, 20});
    run_phase(4'b0011, 0);

    // Frame timeout
    dat[3] = 8'hC3;
    force_q.push_back('{2, 2, 0});
    run_phase(4'b1000, 0);

    // Reset while client 2 is mid-frame
    if (!aborted) begin
      dat[2] = 8'hA7;
      mode_q.push_back('{0, 1, 300});
      e = '{0, 2, 8'hA7, 2};
      exp_q.push_back(e);
      e = '{1, 2, 8'h00, 0};
      exp_q.push_back(e);
      req = 4'b0100;
      got = 1'b0;
      for (int k = 0; k < 20 && !got; k++) begin
        @(negedge clk);
        #1;
        if (|ack) got = 1'b1;
      end
      chk(got, "reset_test_ack_seen", got, 1);
      req = '0;
      repeat (20) @(negedge clk);
      #1;
      rst = 1'b1;
      @(negedge clk);
      #1;
      check_all_zero("midframe_reset");
      rst = 1'b0;
      exp_q.delete();
      m_ptr = 0;
      for (int k = 0; k < 500 && uart_active; k++) @(negedge clk);
      #1;
      // Pointer is back at 0, so client 2 wins over client 3
      dat[2] = 8'h5A; dat[3] = 8'h6B;
      run_phase(4'b1100, 0);
    end

    // Randomized phases
    for (int p = 0; p < 30; p++) begin
      logic [N-1:0] m;
      int           hk;
      for (int i = 0; i < N; i++) dat[i] = 8'($urandom);
      m = 4'($urandom_range(1, 15));
      hk = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 5) : 0;
      run_phase(m, hk);
    end

    repeat (5) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #(800_000);
    $display("FAIL watchdog: simulation exceeded time limit, compared %0d", n_cmp);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad + 1);
    $fatal(1, "watchdog expired");
  end

endmodule
